motor_pwm_executor: RTL and testbench

Consumes 5-bit robot instructions (`{torque[2:0], dir[1:0]}`) and turns each one into a timed drive phase on the motor side. It accepts one instruction per valid/ready handshake from the instruction FIFO read side and drives left and right motor direction and PWM lines for a fixed execution window. It then pulses `done` and returns to idle. It is the decoding end of the instruction encoding produced by the switch/FIFO front end.

---
 rtl/robot_pkg.sv | 32 +++
 rtl/motor_pwm_executor_if.sv | 11 +
 rtl/motor_pwm_executor_pwm_gen.sv | 48 ++++
 rtl/motor_pwm_executor.sv | 101 ++++++++++
 tb/tb_motor_pwm_executor.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/robot_pkg.sv
// Shared robot instruction types: direction codes, torque width and the packed
// instruction word, plus the direction-to-motor mapping.
package robot_pkg;

  localparam int TORQUE_W = 3;

  typedef enum logic [1:0] {
    DIR_FWD   = 2'b00,
    DIR_REV   = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef struct packed {
    logic [TORQUE_W-1:0] torque;
    dir_t                dir;
  } instr_t;

  // Returns {left_dir, right_dir}; 1 = forward. Turns spin the inner wheel backwards.
  function automatic logic [1:0] motor_dirs(dir_t d);
    logic [1:0] lr;
    case (d)
      DIR_FWD:   lr = 2'b11;
      DIR_REV:   lr = 2'b00;
      DIR_LEFT:  lr = 2'b01;
      DIR_RIGHT: lr = 2'b10;
      default:   lr = 2'b11;
    endcase
    return lr;
  endfunction

endpackage

// File: rtl/motor_pwm_executor_if.sv
// Instruction handshake between the FIFO read side (master) and the executor (slave).
interface motor_pwm_executor_if;
  import robot_pkg::*;

  instr_t instr;
  logic   instr_valid;
  logic   instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/motor_pwm_executor_pwm_gen.sv
// Eight-step PWM: a prescaler advances a 3-bit step counter, output is high
// while step < duty. The output is registered against the post-edge step value.
module pwm_gen
  import robot_pkg::*;
#(
  parameter int PRESCALE = 6250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [TORQUE_W-1:0] duty,
  output logic                pwm
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     presc_reg, presc_next;
  logic [TORQUE_W-1:0] step_reg, step_next;

  always_comb begin
    presc_next = presc_reg;
    step_next  = step_reg;
    if (clear) begin
      presc_next = '0;
      step_next  = '0;
    end else if (presc_reg == PS_LAST) begin
      presc_next = '0;
      step_next  = step_reg + 1'b1;
    end else begin
      presc_next = presc_reg + 1'b1;
    end
  end

  // Comparing the next step keeps pwm aligned with the counters it reflects.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
      step_reg  <= '0;
      pwm       <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      step_reg  <= step_next;
      pwm       <= (step_next < duty);
    end
  end

endmodule

// File: rtl/motor_pwm_executor.sv
// Executes one robot instruction at a time: drives motor directions and PWM
// for EXEC_CYCLES cycles, then pulses done for one cycle and returns to idle.
module motor_pwm_executor
  import robot_pkg::*;
#(
  parameter int PRESCALE    = 6250,
  parameter int EXEC_CYCLES = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  motor_pwm_executor_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  left_dir,
  output logic                  right_dir,
  output logic                  left_pwm,
  output logic                  right_pwm
);

  localparam int EX_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [EX_W-1:0] EXEC_LAST = EX_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} exec_state_t;

  exec_state_t         state_reg;
  instr_t              instr_reg;
  logic [EX_W-1:0]     exec_reg;
  logic                accept;
  logic                run_continue;
  logic                pwm_clear;
  logic [TORQUE_W-1:0] pwm_duty;
  logic                pwm_out;

  assign bus.instr_ready = (state_reg == IDLE) && !abort;
  assign accept          = bus.instr_valid && bus.instr_ready;
  assign run_continue    = (state_reg == RUN) && !abort && (exec_reg != EXEC_LAST);

  // PWM restarts from step 0 on accept and is forced low whenever RUN is not continuing.
  assign pwm_clear = !run_continue;
  assign pwm_duty  = accept       ? bus.instr.torque :
                     run_continue ? instr_reg.torque : '0;

  pwm_gen #(
    .PRESCALE (PRESCALE)
  ) u_pwm_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (pwm_clear),
    .duty  (pwm_duty),
    .pwm   (pwm_out)
  );

  assign left_pwm  = pwm_out;
  assign right_pwm = pwm_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      instr_reg <= '0;
      exec_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      left_dir  <= 1'b1;
      right_dir <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          exec_reg <= '0;
          if (accept) begin
            instr_reg               <= bus.instr;
            state_reg               <= RUN;
            busy                    <= 1'b1;
            {left_dir, right_dir}   <= motor_dirs(bus.instr.dir);
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (exec_reg == EXEC_LAST) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            exec_reg <= exec_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_pwm_executor.sv
// Randomized and directed bench for motor_pwm_executor, checked cycle by cycle
// against a model that tracks cycles elapsed since the accepted instruction.
module tb_motor_pwm_executor;

  localparam int P    = 2;
  localparam int EXEC = 40;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic busy, done, left_dir, right_dir, left_pwm, right_pwm;

  motor_pwm_executor_if bus();

  motor_pwm_executor #(
    .PRESCALE    (P),
    .EXEC_CYCLES (EXEC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .left_dir  (left_dir),
    .right_dir (right_dir),
    .left_pwm  (left_pwm),
    .right_pwm (right_pwm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: phase 0 = idle, 1..EXEC = RUN cycle k after accept, EXEC+1 = done cycle.
  int         phase = 0;
  int         m_tq  = 0;
  logic       m_l   = 1'b1;
  logic       m_r   = 1'b1;
  logic [4:0] m_ins = '0;
  int         hi_cnt = 0;
  int         n_acc  = 0;
  int         n_txn  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_dirs(input logic [1:0] d);
    case (d)
      2'b00:   return 2'b11;
      2'b01:   return 2'b00;
      2'b10:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // High cycles in a full window: whole 8P periods plus the partial tail.
  function automatic int exp_high(input int tq);
    int full, rem, tail;
    full = EXEC / (8 * P);
    rem  = EXEC % (8 * P);
    tail = (rem < tq * P) ? rem : tq * P;
    return full * tq * P + tail;
  endfunction

  task automatic log_txn(input string how);
    n_txn++;
    $display("txn %0d instr=%b torque=%0d result=%s pwm_high=%0d", n_txn, m_ins, m_tq, how, hi_cnt);
  endtask

  // One clock cycle: drive inputs, check ready, step model, check registered outputs.
  task automatic cyc(input logic r, input logic v, input logic [4:0] ins, input logic ab);
    logic acc;
    logic exp_pwm;
    rst             = r;
    bus.instr_valid = v;
    bus.instr       = ins;
    abort           = ab;
    #1;
    check_eq("instr_ready", bus.instr_ready, (phase == 0) && !ab);
    acc = !r && v && (phase == 0) && !ab;
    @(posedge clk);
    #1;
    if (r) begin
      if (phase != 0) log_txn("reset");
      phase = 0;
      m_l = 1'b1;
      m_r = 1'b1;
    end else if (phase == 0) begin
      if (acc) begin
        phase  = 1;
        m_ins  = ins;
        m_tq   = int'(ins[4:2]);
        {m_l, m_r} = exp_dirs(ins[1:0]);
        hi_cnt = 0;
        n_acc++;
      end
    end else if (phase <= EXEC) begin
      if (ab) begin
        log_txn("abort");
        phase = 0;
      end else begin
        phase++;
      end
    end else begin
      phase = 0;
    end
    exp_pwm = (phase >= 1 && phase <= EXEC) && ((((phase - 1) / P) % 8) < m_tq);
    check_eq("busy", busy, phase != 0);
    check_eq("done", done, phase == EXEC + 1);
    check_eq("left_pwm", left_pwm, exp_pwm);
    check_eq("right_pwm", right_pwm, exp_pwm);
    check_eq("left_dir", left_dir, m_l);
    check_eq("right_dir", right_dir, m_r);
    if (phase >= 1 && phase <= EXEC && left_pwm === 1'b1) hi_cnt++;
    if (phase == EXEC + 1) begin
      check_eq("duty_total", hi_cnt, exp_high(m_tq));
      log_txn("done");
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (phase != 0 && budget < 200) begin
      cyc(1'b0, 1'b0, 5'b0, 1'b0);
      budget++;
    end
    check_eq("idle_timeout", phase != 0, 1'b0);
  endtask

  task automatic send_and_finish(input logic [4:0] ins);
    cyc(1'b0, 1'b1, ins, 1'b0);
    wait_idle();
  endtask

  initial begin
    int acc_before;
    int budget;
    rst = 1'b1;
    abort = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    @(posedge clk);
    #1;

    // Reset held two cycles, then quiet idle.
    cyc(1'b1, 1'b0, 5'b0, 1'b0);
    cyc(1'b1, 1'b0, 5'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 5'b0, 1'b0);

    send_and_finish(5'b100_00);
    send_and_finish(5'b111_10);
    send_and_finish(5'b001_11);

    // Torque 0 followed by a second word held valid through the whole run.
    cyc(1'b0, 1'b1, 5'b000_01, 1'b0);
    acc_before = n_acc;
    budget = 0;
    while (n_acc == acc_before && budget < 100) begin
      cyc(1'b0, 1'b1, 5'b101_00, 1'b0);
      budget++;
    end
    check_eq("backpressure_timeout", n_acc == acc_before, 1'b0);
    wait_idle();

    // Abort at RUN cycle 10, then abort together with valid in idle.
    cyc(1'b0, 1'b1, 5'b110_11, 1'b0);
    repeat (9) cyc(1'b0, 1'b0, 5'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'b0, 1'b1);
    cyc(1'b0, 1'b1, 5'b111_00, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 5'b0, 1'b0);

    // Abort on the final RUN cycle suppresses done.
    cyc(1'b0, 1'b1, 5'b011_01, 1'b0);
    repeat (EXEC - 1) cyc(1'b0, 1'b0, 5'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'b0, 1'b1);
    cyc(1'b0, 1'b0, 5'b0, 1'b0);

    // Reset at RUN cycle 20, then a fresh instruction.
    cyc(1'b0, 1'b1, 5'b101_10, 1'b0);
    repeat (19) cyc(1'b0, 1'b0, 5'b0, 1'b0);
    cyc(1'b1, 1'b0, 5'b0, 1'b0);
    send_and_finish(5'b010_11);

    // Random traffic with occasional abort and reset.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(149) == 0, $urandom_range(1) == 1,
          5'($urandom_range(31)), $urandom_range(39) == 0);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
